// File: rtl/conv_window_sequencer.sv
// Builds KxK raster-order convolution windows from a combinational image ROM.
// Optional CONV_WIN_POPCOUNT_EN adds a registered per-window ones count.
module conv_window_sequencer #(
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5,
    parameter int K      = 3,
    parameter int ADDR_W = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic [ADDR_W-1:0]   o_rom_addr,
    input  logic                i_rom_pixel,
    output logic [K*K-1:0]      o_window,
    output logic [7:0]          o_row,
    output logic [7:0]          o_col,
    output logic                o_win_valid,
    input  logic                i_win_ready,
    output logic                o_busy,
    output logic                o_done
`ifdef CONV_WIN_POPCOUNT_EN
    ,
    output logic [$clog2(K*K+1)-1:0] o_popcount
`endif
);

    localparam int KKW = $clog2(K*K+1);
    localparam int KW  = $clog2(K+1);

    localparam logic [KKW-1:0] K_LAST   = KKW'(K*K-1);
    localparam logic [KW-1:0]  KC_LAST  = KW'(K-1);
    localparam logic [7:0]     COL_LAST = 8'(IMG_W-K);
    localparam logic [7:0]     ROW_LAST = 8'(IMG_H-K);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
    } state_t;

    state_t         state;
    logic [KKW-1:0] k;
    logic [KW-1:0]  kr;
    logic [KW-1:0]  kc;
    logic           fetch_last;
    logic           win_last;
    logic           accept;

    assign fetch_last = (k == K_LAST);
    assign win_last   = (o_row == ROW_LAST) && (o_col == COL_LAST);
    assign accept     = o_win_valid && i_win_ready;

    // Address is driven only while fetching so the ROM sees 0 otherwise
    always_comb begin
        o_rom_addr = '0;
        if (state == FETCH) begin
            o_rom_addr = ADDR_W'((32'(o_row) + 32'(kr)) * 32'(IMG_W)
                                 + 32'(o_col) + 32'(kc));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            k           <= '0;
            kr          <= '0;
            kc          <= '0;
            o_window    <= '0;
            o_row       <= '0;
            o_col       <= '0;
            o_win_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= FETCH;
                        o_busy <= 1'b1;
                        o_row  <= '0;
                        o_col  <= '0;
                        k      <= '0;
                        kr     <= '0;
                        kc     <= '0;
                    end
                end
                FETCH: begin
                    o_window[k] <= i_rom_pixel;
                    if (fetch_last) begin
                        state       <= PRESENT;
                        o_win_valid <= 1'b1;
                        k           <= '0;
                        kr          <= '0;
                        kc          <= '0;
                    end else begin
                        k <= k + 1'b1;
                        if (kc == KC_LAST) begin
                            kc <= '0;
                            kr <= kr + 1'b1;
                        end else begin
                            kc <= kc + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        o_win_valid <= 1'b0;
                        if (win_last) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= FETCH;
                            if (o_col == COL_LAST) begin
                                o_col <= '0;
                                o_row <= o_row + 8'd1;
                            end else begin
                                o_col <= o_col + 8'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_WIN_POPCOUNT_EN
    // Restart the count on the first pixel of every window
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_popcount <= '0;
        end else if (state == FETCH) begin
            o_popcount <= ((k == '0) ? '0 : o_popcount) + KKW'(i_rom_pixel);
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed + randomized bench for conv_window_sequencer against a window model.
// Build with CONV_WIN_POPCOUNT_EN defined to also cover o_popcount.
module tb_conv_window_sequencer;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int K  = 3;
    localparam int AW = 5;
    localparam int KK = K * K;
    localparam int NC = W - K + 1;
    localparam int NW = (H - K + 1) * (W - K + 1);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AW-1:0] o_rom_addr;
    logic          i_rom_pixel;
    logic [KK-1:0] o_window;
    logic [7:0]    o_row;
    logic [7:0]    o_col;
    logic          o_win_valid;
    logic          i_win_ready = 1'b0;
    logic          o_busy;
    logic          o_done;
`ifdef CONV_WIN_POPCOUNT_EN
    logic [$clog2(KK+1)-1:0] o_popcount;
`endif

    logic [31:0]   img;
    logic [KK-1:0] seen [NW];
    int            n_checks = 0;
    int            n_fail = 0;

    assign i_rom_pixel = img[o_rom_addr];

    always #5 i_clk = ~i_clk;

    conv_window_sequencer #(
        .IMG_W (W),
        .IMG_H (H),
        .K     (K),
        .ADDR_W(AW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .o_rom_addr (o_rom_addr),
        .i_rom_pixel(i_rom_pixel),
        .o_window   (o_window),
        .o_row      (o_row),
        .o_col      (o_col),
        .o_win_valid(o_win_valid),
        .i_win_ready(i_win_ready),
        .o_busy     (o_busy),
`ifdef CONV_WIN_POPCOUNT_EN
        .o_popcount (o_popcount),
`endif
        .o_done     (o_done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [KK-1:0] model_win(input int r, input int c);
        logic [KK-1:0] w;
        w = '0;
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
                w[a*K+b] = img[(r+a)*W + c + b];
        return w;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, o_win_valid, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_addr"}, o_rom_addr, 0);
        check({tag, "_window"}, o_window, 0);
        check({tag, "_row"}, o_row, 0);
        check({tag, "_col"}, o_col, 0);
`ifdef CONV_WIN_POPCOUNT_EN
        check({tag, "_popcount"}, o_popcount, 0);
`endif
    endtask

    // mode 0: ready high, 1: random ready and stray starts,
    // 2: ready low 5 cycles on window (1,1)
    task automatic scan(input int mode, input int abort_after, output int nwin);
        int widx = 0;
        int f = 0;
        int hold = 0;
        int phase = 0;
        int cyc;
        bit rdy;
        bit fin = 0;
        int r;
        int c;
        @(negedge i_clk);
        i_start = 1'b1;
        i_win_ready = (mode == 0);
        @(negedge i_clk);
        i_start = 1'b0;
        for (cyc = 1; cyc < 2000 && !fin; cyc++) begin
            r = widx / NC;
            c = widx % NC;
            if (phase == 1) begin
                check("done_pulse", o_done, 1);
                check("done_busy", o_busy, 1);
                i_start = 1'b0;
                phase = 2;
            end else if (phase == 2) begin
                check("done_low", o_done, 0);
                check("busy_low", o_busy, 0);
                fin = 1;
            end else if (o_win_valid) begin
                check("win", o_window, model_win(r, c));
                check("row", o_row, r);
                check("col", o_col, c);
                check("addr_present", o_rom_addr, 0);
                check("busy_present", o_busy, 1);
`ifdef CONV_WIN_POPCOUNT_EN
                check("popcount", o_popcount, $countones(model_win(r, c)));
`endif
                if (mode == 0) check("valid_time", cyc, 10 + 10 * widx);
                rdy = 1'b1;
                if (mode == 1) rdy = $urandom_range(0, 1) == 1;
                if (mode == 2 && widx == 4 && hold < 5) begin
                    rdy = 1'b0;
                    hold++;
                end
                if (mode == 1) i_start = ($urandom_range(0, 3) == 0);
                i_win_ready = rdy;
                if (rdy) begin
                    seen[widx] = o_window;
                    widx++;
                    f = 0;
                    if (widx == NW) phase = 1;
                end
            end else begin
                check("fetch_len", f < KK, 1);
                check("fetch_addr", o_rom_addr, (r + f / K) * W + c + f % K);
                check("fetch_done", o_done, 0);
                check("fetch_busy", o_busy, 1);
                f++;
                if (mode == 1) begin
                    i_win_ready = $urandom_range(0, 1) == 1;
                    i_start = ($urandom_range(0, 3) == 0);
                end
                if (abort_after > 0 && widx == abort_after && f == 3) begin
                    #1 i_rst = 1'b1;
                    #1 check_idle_zero("abort");
                    i_start = 1'b0;
                    repeat (2) @(negedge i_clk);
                    i_rst = 1'b0;
                    repeat (12) begin
                        @(negedge i_clk);
                        check("abort_no_done", o_done, 0);
                        check("abort_idle", o_busy, 0);
                    end
                    fin = 1;
                end
            end
            if (!fin) @(negedge i_clk);
        end
        check("scan_timeout", fin, 1);
        i_start = 1'b0;
        i_win_ready = 1'b0;
        nwin = widx;
    endtask

    initial begin
        int nwin;
        img = 32'h5555_5555;
        #1 check_idle_zero("reset");
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check_idle_zero("post_reset");

        scan(0, 0, nwin);
        check("cb_count", nwin, NW);
        check("cb_w00", seen[0], 9'h155);
        check("cb_w01", seen[1], 9'h0AA);
        check("cb_w02", seen[2], 9'h155);
        check("cb_w10", seen[3], 9'h0AA);
        check("cb_w22", seen[8], 9'h155);

        scan(2, 0, nwin);
        check("bp_count", nwin, NW);

        repeat (3) begin
            img = $urandom();
            scan(1, 0, nwin);
            check("rand_count", nwin, NW);
        end

        img = $urandom();
        scan(0, 4, nwin);
        check("abort_count", nwin, 4);
        scan(0, 0, nwin);
        check("restart_count", nwin, NW);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Sequences reads from the binary image ROM (combinational, one pixel per address) to build K×K convolution windows in raster order, stride 1, no padding. Presents each assembled window to the downstream convolution/MAC stage over a valid/ready handshake. A `i_start` pulse scans one full image, and `o_done` marks the end of the scan. This block is the sole address master of the image ROM.

## Interface
- `IMG_W`, default 5: image width in pixels.
- `IMG_H`, default 5: image height in pixels.
- `K`, default 3: kernel edge. Requires `K <= IMG_W` and `K <= IMG_H`.
- `ADDR_W`, default 5: ROM address width. Requires `2^ADDR_W >= IMG_W*IMG_H`.
- `i_clk` input 1: the only clock. All state updates on its rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_start` input 1: starts a scan. Sampled only in IDLE.
- `o_rom_addr` output ADDR_W: address to the image ROM.
- `i_rom_pixel` input 1: ROM data for `o_rom_addr`, valid in the same cycle.
- `o_window` output K*K: assembled window. Bit `kr*K+kc` is the pixel at window offset (kr,kc). Bit 0 is top-left.
- `o_row` output 8: output-map row of the presented window.
- `o_col` output 8: output-map column of the presented window.
- `o_win_valid` output 1: window, row and column are valid.
- `i_win_ready` input 1: consumer accepts the window.
- `o_busy` output 1: high in every state except IDLE.
- `o_done` output 1: one-cycle pulse after the last window is accepted.

## Operation
- States and transitions:
  - IDLE → FETCH when `i_start` is high. Clears row, col and k.
  - FETCH → PRESENT after the fetch cycle with k = K*K-1.
  - PRESENT → FETCH on accept, if windows remain.
  - PRESENT → DONE on accept of the last window.
  - DONE → IDLE unconditionally.
- FETCH runs one cycle per pixel, with k from 0 to K*K-1:
  - kr = k / K, kc = k % K. Use counters, not a divider.
  - `o_rom_addr = (row+kr)*IMG_W + (col+kc)`, computed in ADDR_W bits. It cannot overflow, given the parameter constraint.
  - On the clock edge, `i_rom_pixel` is written into window bit k.
- PRESENT:
  - `o_win_valid` is high.
  - `o_window`, `o_row` and `o_col` are stable until accepted.
  - Accept is `o_win_valid && i_win_ready` at a rising edge.
- Advance on accept:
  - If col == IMG_W-K: col = 0 and row = row+1. Otherwise col = col+1.
  - The last window is row == IMG_H-K and col == IMG_W-K.
- `o_rom_addr` is 0 outside FETCH.
- `o_window` retains its last value outside PRESENT. It is not cleared between windows, and each bit is overwritten before the next PRESENT.
- `i_start` is ignored in FETCH, PRESENT and DONE. It does not queue.
- `i_win_ready` is ignored outside PRESENT.
- A scan yields (IMG_H-K+1)*(IMG_W-K+1) windows, which is 9 for the defaults.

## Timing
- Reset values: state IDLE, `o_rom_addr` 0, `o_window` 0, `o_row` 0, `o_col` 0, `o_win_valid` 0, `o_busy` 0, `o_done` 0. Reset also clears `o_popcount` when it is compiled in.
- Reset asserted mid-scan aborts immediately: no `o_done`, no further windows.
- `i_start` high at edge E gives the first FETCH cycle at E+1. The first `o_win_valid` appears at E+1+K*K, which is cycle 10 for the defaults.
- Each window takes K*K fetch cycles plus at least one PRESENT cycle. With `i_win_ready` held high, windows are 10 cycles apart.
- The accept of the last window at edge A gives `o_done` high in cycle A+1 only, and `o_busy` low from A+2.
- `o_busy` goes high the cycle after `i_start` is sampled and stays high through DONE.

## Configuration
- `CONV_WIN_POPCOUNT_EN`
  - Defined: adds output `o_popcount`, width $clog2(K*K+1), 4 bits by default.
    - It is a registered count of ones in the window.
    - It is accumulated during FETCH, valid with `o_win_valid` and stable while presented.
    - It is reset to 0 at the start of each window's FETCH.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert `i_rst` asynchronously, with no clock edge. → All outputs go to 0 immediately and the state is IDLE.
- Checkerboard ROM (pixel = 1 at even addresses), `i_start` pulse, `i_win_ready` tied high.
  - → Windows in order (r,c): (0,0)=9'h155, (0,1)=9'h0AA, (0,2)=9'h155, (1,0)=9'h0AA, … alternating. Exactly 9 windows.
  - → First valid at cycle 10 after start, 10 cycles apart.
  - → `o_done` one cycle after the 9th accept.
- Address trace for window (0,0): `o_rom_addr` sequence 0,1,2,5,6,7,10,11,12. For window (2,2): 12,13,14,17,18,19,22,23,24.
- Backpressure: hold `i_win_ready` low for 5 cycles on window (1,1). → `o_win_valid`, `o_window`, `o_row`=1 and `o_col`=1 stay stable, `o_rom_addr` stays 0, and no advance occurs until accept.
- `i_start` re-pulsed mid-scan → ignored, and the window count stays 9. `i_rst` pulsed after the 4th window → IDLE, no `o_done`. A fresh `i_start` then restarts at (0,0).
- With `CONV_WIN_POPCOUNT_EN` on the checkerboard: `o_popcount` = 5, 4, 5, 4, … in step with the windows.
